// File: rtl/custom_mem_arb_pkg.sv
// Shared types and sizing helpers for the MEM port arbiter.
package custom_mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // Width of a counter that must hold 0..max_outstanding inclusive.
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/custom_mem_arb_id_fifo.sv
// In-order FIFO of issuing-port indices for transactions awaiting a response.
module custom_mem_arb_id_fifo
    import custom_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write on push.
    // NOTE: the storage array has no reset; entries are only read once count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/custom_mem_port_arbiter.sv
// N:1 round-robin arbiter for the MEM req/gnt/valid protocol with request lock
// and in-order response routing back to the issuing port.
module custom_mem_port_arbiter
    import custom_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS        = 2,
    parameter int LOCAL_DATA_WIDTH = 32,
    parameter int LOCAL_ADDR_WIDTH = 32,
    parameter int MAX_OUTSTANDING  = 2,
    localparam int BE_W = LOCAL_DATA_WIDTH / 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NUM_PORTS-1:0]                        s_mem_req,
    output logic [NUM_PORTS-1:0]                        s_mem_gnt,
    output logic [NUM_PORTS-1:0]                        s_mem_valid,
    input  logic [NUM_PORTS-1:0][LOCAL_ADDR_WIDTH-1:0]  s_mem_addr,
    input  logic [NUM_PORTS-1:0][LOCAL_DATA_WIDTH-1:0]  s_mem_wdata,
    input  logic [NUM_PORTS-1:0]                        s_mem_we,
    input  logic [NUM_PORTS-1:0][BE_W-1:0]              s_mem_be,
    output logic [NUM_PORTS-1:0][LOCAL_DATA_WIDTH-1:0]  s_mem_rdata,
    output logic                                        m_mem_req,
    input  logic                                        m_mem_gnt,
    input  logic                                        m_mem_valid,
    output logic [LOCAL_ADDR_WIDTH-1:0]                 m_mem_addr,
    output logic [LOCAL_DATA_WIDTH-1:0]                 m_mem_wdata,
    output logic                                        m_mem_we,
    output logic [BE_W-1:0]                             m_mem_be,
    input  logic [LOCAL_DATA_WIDTH-1:0]                 m_mem_rdata,
    output logic                                        err_o
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;
    logic [IDX_W-1:0] winner;
    logic             winner_valid;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
    endfunction

    // Round-robin search: first requesting port at or after rr_ptr, wrapping.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin : rr_pick
        int unsigned cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!rr_found && s_mem_req[IDX_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    // A locked port keeps the downstream slot until it is granted or withdraws.
    always_comb begin
        winner       = rr_idx;
        winner_valid = rr_found;
        if (state == LOCKED) begin
            winner       = lock_idx;
            winner_valid = s_mem_req[lock_idx];
        end
    end

    assign m_mem_req = winner_valid && !fifo_full;
    assign handshake = m_mem_req && m_mem_gnt;
    assign pop       = m_mem_valid && !fifo_empty;

    // Downstream payload from the selected port, zero when nobody is selected; grant back to it.
    always_comb begin
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_mem_we    = 1'b0;
        m_mem_be    = '0;
        s_mem_gnt   = '0;
        if (winner_valid) begin
            m_mem_addr  = s_mem_addr[winner];
            m_mem_wdata = s_mem_wdata[winner];
            m_mem_we    = s_mem_we[winner];
            m_mem_be    = s_mem_be[winner];
        end
        if (handshake) begin
            s_mem_gnt[winner] = 1'b1;
        end
    end

    // Route a downstream response to the port at the head of the ID FIFO.
    always_comb begin
        s_mem_valid = '0;
        s_mem_rdata = '0;
        if (pop) begin
            s_mem_valid[head] = 1'b1;
            s_mem_rdata[head] = m_mem_rdata;
        end
    end

    // Lock FSM and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        rr_ptr <= idx_inc(winner);
                    end else if (m_mem_req) begin
                        state    <= LOCKED;
                        lock_idx <= winner;
                    end
                end
                LOCKED: begin
                    if (handshake) begin
                        state  <= IDLE;
                        rr_ptr <= idx_inc(winner);
                    end else if (!winner_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error: a response arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (m_mem_valid && (fifo_count == '0)) begin
            err_o <= 1'b1;
        end
    end

    custom_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (handshake),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
